// File: rtl/cbus_ram_responder.sv
// rtl/cbus_ram_responder.sv - cbus responder serving single-beat and burst transfers from on-chip RAM
package cbus_pkg;
    localparam logic [3:0] MLEN1  = 4'd0;
    localparam logic [3:0] MLEN2  = 4'd1;
    localparam logic [3:0] MLEN4  = 4'd3;
    localparam logic [3:0] MLEN8  = 4'd7;
    localparam logic [3:0] MLEN16 = 4'd15;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_ram_responder
    import cbus_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 2,
    parameter int INIT_ZERO = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp,
    output logic       busy
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] base_idx;
    logic [3:0]    len_q;
    logic          is_write_q;
    logic [3:0]    beat_cnt;
    logic [3:0]    lat_cnt;

    logic [AW-1:0] idx;
    logic          in_burst;
    logic          last_beat;
    logic          wr_en;

    // Power-up contents only; reset deliberately leaves the array alone.
    logic [31:0] mem [MEM_WORDS] = '{default: (INIT_ZERO != 0) ? 32'h0 : 32'hx};

    // size is implied by the strobe; byte offset and high address bits do not select a word.
    logic unused_bits;
    assign unused_bits = ^{creq.size, creq.addr[1:0], creq.addr[31:AW+2]};

    // Word index wraps naturally at the RAM depth; no line wrapping.
    assign idx       = base_idx + AW'(beat_cnt);
    assign in_burst  = (state == ST_BURST);
    assign last_beat = (beat_cnt == len_q);
    assign wr_en     = in_burst && is_write_q && creq.valid;
    assign busy      = (state != ST_IDLE);

    // Transfer sequencing: accept in IDLE, count down latency, then one beat per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            base_idx   <= '0;
            len_q      <= '0;
            is_write_q <= 1'b0;
            beat_cnt   <= '0;
            lat_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (creq.valid) begin
                        base_idx   <= creq.addr[AW+1:2];
                        len_q      <= creq.len;
                        is_write_q <= creq.is_write;
                        beat_cnt   <= '0;
                        lat_cnt    <= 4'(LATENCY);
                        state      <= (LATENCY > 0) ? ST_WAIT : ST_BURST;
                    end
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - 4'd1;
                    if (!creq.valid) begin
                        state <= ST_IDLE;
                    end else if (lat_cnt == 4'd1) begin
                        state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (!creq.valid || last_beat) begin
                        state    <= ST_IDLE;
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Byte-lane write of the current beat using the live data and strobe.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (creq.strobe[k]) begin
                    mem[idx][8*k +: 8] <= creq.data[8*k +: 8];
                end
            end
        end
    end

    // Response is a pure function of state so reset clears it immediately.
    always_comb begin
        cresp = '0;
        if (in_burst) begin
            cresp.ready = 1'b1;
            cresp.last  = last_beat;
            if (!is_write_q) begin
                cresp.data = mem[idx];
            end
        end
    end
endmodule

// File: tb/tb_cbus_ram_responder.sv
// tb/tb_cbus_ram_responder.sv - randomized self-checking bench with a word-array memory model
module tb_cbus_ram_responder;
    import cbus_pkg::*;

    localparam int MEM_WORDS = 4096;

    logic       clk;
    logic       reset;
    cbus_req_t  req2, req0;
    cbus_resp_t resp2, resp0;
    logic       busy2, busy0;

    int ncomp;
    int nfail;

    logic [31:0] ref_mem [2][MEM_WORDS];
    logic [31:0] wbuf [16];
    logic [31:0] rdbuf [16];
    logic [31:0] abuf [4];
    logic [3:0]  lens [5];

    cbus_ram_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(2), .INIT_ZERO(1)) u_dut_lat2 (
        .clk(clk), .reset(reset), .creq(req2), .cresp(resp2), .busy(busy2)
    );

    cbus_ram_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(0), .INIT_ZERO(1)) u_dut_lat0 (
        .clk(clk), .reset(reset), .creq(req0), .cresp(resp0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input bit sel);
        return sel ? 0 : 2;
    endfunction

    function automatic cbus_resp_t get_resp(input bit sel);
        return sel ? resp0 : resp2;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? busy0 : busy2;
    endfunction

    task automatic drive(input bit sel, input cbus_req_t r);
        if (sel) req0 = r;
        else     req2 = r;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one transfer starting at a negedge where the DUT is idle; ends on the gap cycle after it.
    task automatic xfer(input bit sel, input bit wr, input logic [31:0] addr,
                        input logic [3:0] len, input logic [3:0] strobe, input bit keep);
        cbus_req_t  r;
        cbus_resp_t rs;
        int c, nb, idx;
        bit done;
        r = '0;
        r.valid = 1'b1; r.is_write = wr; r.size = 2'd2; r.addr = addr;
        r.len = len; r.strobe = strobe; r.data = wbuf[0];
        drive(sel, r);
        c = 0; nb = 0; done = 0;
        while (!done && c < 64) begin
            @(negedge clk);
            c++;
            r.data = wbuf[nb];
            drive(sel, r);
            rs = get_resp(sel);
            if (rs.ready) begin
                if (nb == 0) chk("first_beat_cycle", c, lat_of(sel) + 1);
                idx = (int'(addr >> 2) + nb) % MEM_WORDS;
                chk("last_flag", {31'b0, rs.last}, {31'b0, (nb == int'(len))});
                chk("burst_busy", {31'b0, get_busy(sel)}, 32'd1);
                if (wr) begin
                    chk("write_resp_data_zero", rs.data, 32'h0);
                    for (int k = 0; k < 4; k++)
                        if (strobe[k]) ref_mem[sel][idx][8*k +: 8] = wbuf[nb][8*k +: 8];
                end else begin
                    chk("read_data", rs.data, ref_mem[sel][idx]);
                    rdbuf[nb] = rs.data;
                end
                if (nb == int'(len)) done = 1;
                nb++;
            end else begin
                chk("wait_data_zero", rs.data, 32'h0);
                chk("wait_last_zero", {31'b0, rs.last}, 32'd0);
                chk("wait_busy", {31'b0, get_busy(sel)}, 32'd1);
            end
        end
        if (!done) begin
            ncomp++;
            nfail++;
            $error("FAIL xfer_timeout: observed %0d beats expected %0d", nb, int'(len) + 1);
        end
        @(negedge clk);
        rs = get_resp(sel);
        chk("gap_ready", {31'b0, rs.ready}, 32'd0);
        chk("gap_busy", {31'b0, get_busy(sel)}, 32'd0);
        r.valid = keep;
        drive(sel, r);
    endtask

    initial begin
        cbus_req_t r;
        int c, nb;
        bit sel, nsel, wr, keep;
        logic [31:0] addr;
        logic [3:0]  len;
        int base;

        ncomp = 0;
        nfail = 0;
        lens[0] = MLEN1; lens[1] = MLEN2; lens[2] = MLEN4; lens[3] = MLEN8; lens[4] = MLEN16;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < MEM_WORDS; i++) ref_mem[s][i] = 32'h0;
        for (int i = 0; i < 16; i++) wbuf[i] = 32'h0;
        req2 = '0;
        req0 = '0;
        reset = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, resp2.ready}, 32'd0);
        chk("rst_last", {31'b0, resp2.last}, 32'd0);
        chk("rst_data", resp2.data, 32'h0);
        chk("rst_busy", {31'b0, busy2}, 32'd0);
        chk("rst_busy0", {31'b0, busy0}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single read with LATENCY=2
        wbuf[0] = 32'hDEADBEEF;
        xfer(0, 1, 32'h40, MLEN1, 4'hF, 0);
        xfer(0, 0, 32'h40, MLEN1, 4'hF, 0);
        chk("single_read_value", rdbuf[0], 32'hDEADBEEF);

        // Burst refill
        for (int i = 0; i < 4; i++) wbuf[i] = i + 1;
        xfer(0, 1, 32'h100, MLEN4, 4'hF, 0);
        xfer(0, 0, 32'h100, MLEN4, 4'hF, 0);
        for (int i = 0; i < 4; i++) chk("refill_value", rdbuf[i], i + 1);

        // Write-back then refill with valid held high, on the zero-latency responder
        for (int i = 0; i < 4; i++) begin
            abuf[i] = $urandom;
            wbuf[i] = abuf[i];
        end
        xfer(1, 1, 32'h200, MLEN4, 4'hF, 1);
        xfer(1, 0, 32'h200, MLEN4, 4'hF, 0);
        for (int i = 0; i < 4; i++) chk("wb_refill_value", rdbuf[i], abuf[i]);

        // Sub-word store
        wbuf[0] = 32'h11223344;
        xfer(0, 1, 32'h14, MLEN1, 4'hF, 0);
        wbuf[0] = 32'h0000AB00;
        xfer(0, 1, 32'h14, MLEN1, 4'b0010, 0);
        xfer(0, 0, 32'h14, MLEN1, 4'hF, 0);
        chk("subword_value", rdbuf[0], 32'h1122AB44);

        // Reset on the second beat of an 8-beat read
        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
        xfer(0, 1, 32'h300, MLEN8, 4'hF, 0);
        r = '0;
        r.valid = 1'b1; r.addr = 32'h300; r.len = MLEN8; r.size = 2'd2;
        drive(0, r);
        c = 0; nb = 0;
        while (nb < 2 && c < 64) begin
            @(negedge clk);
            c++;
            if (resp2.ready) nb++;
        end
        chk("midburst_reached_beat2", nb, 2);
        reset = 1'b1;
        #1;
        chk("midrst_ready", {31'b0, resp2.ready}, 32'd0);
        chk("midrst_last", {31'b0, resp2.last}, 32'd0);
        chk("midrst_data", resp2.data, 32'h0);
        chk("midrst_busy", {31'b0, busy2}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        r.valid = 1'b0;
        drive(0, r);
        @(negedge clk);
        xfer(0, 0, 32'h300, MLEN8, 4'hF, 0);
        for (int i = 0; i < 8; i++) chk("post_rst_read", rdbuf[i], ref_mem[0][192 + i]);

        // Zero latency with address wrap at the top of RAM
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE0000 + i;
        xfer(1, 1, (MEM_WORDS - 2) * 4, MLEN4, 4'hF, 0);
        xfer(1, 0, (MEM_WORDS - 2) * 4 + 3, MLEN4, 4'hF, 0);
        for (int i = 0; i < 4; i++) chk("wrap_value", rdbuf[i], 32'hC0DE0000 + i);

        // Random traffic against the model
        nsel = 1'($urandom_range(0, 1));
        for (int t = 0; t < 40; t++) begin
            sel  = nsel;
            nsel = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            base = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 63) : $urandom_range(MEM_WORDS - 16, MEM_WORDS - 1);
            addr = 32'(base * 4 + $urandom_range(0, 3));
            len  = lens[$urandom_range(0, 4)];
            for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
            keep = (t < 39) && (sel == nsel) && ($urandom_range(0, 1) != 0);
            xfer(sel, wr, addr, len, 4'($urandom_range(0, 15)), keep);
            if (!keep) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        req2.valid = 1'b0;
        req0.valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
